// File: rtl/sdp_buffer_arbiter.sv
// Round-robin arbiter/sequencer sharing one simple-dual-port buffer between
// NUM_WR writers on port A and NUM_RD readers on port B, with tagged read responses.

module sdp_rr_arb #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);
   logic [IW-1:0] ptr_q, ptr_d;

   // Linear scan from ptr with wrap; first asserted request wins.
   always_comb begin
      int j;
      j       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         if (!gnt_any && !reset && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
            gnt_any = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
endmodule

module sdp_buffer_arbiter #(
   parameter int NUM_WR         = 2,
   parameter int NUM_RD         = 2,
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 8,
   parameter int READ_LATENCY_B = 1,
   parameter int RD_ID_W        = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_WR-1:0]            wr_req,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
   output logic [NUM_WR-1:0]            wr_gnt,
   input  logic [NUM_RD-1:0]            rd_req,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD-1:0]            rd_gnt,
   output logic                         rd_rsp_valid,
   output logic [RD_ID_W-1:0]           rd_rsp_id,
   output logic [DATA_WIDTH-1:0]        rd_rsp_data,
   output logic                         mem_ena,
   output logic                         mem_wea,
   output logic [ADDR_WIDTH-1:0]        mem_addra,
   output logic [DATA_WIDTH-1:0]        mem_dina,
   output logic                         mem_enb,
   output logic [ADDR_WIDTH-1:0]        mem_addrb,
   output logic                         mem_regceb,
   output logic                         mem_rstb,
   input  logic [DATA_WIDTH-1:0]        mem_doutb
);
   localparam int WIW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   localparam int L   = READ_LATENCY_B;

   logic [WIW-1:0]     wr_idx;
   logic [RD_ID_W-1:0] rd_idx;
   logic               wr_any, rd_any;

   logic                  mem_ena_q, mem_enb_q;
   logic [ADDR_WIDTH-1:0] mem_addra_q, mem_addrb_q;
   logic [DATA_WIDTH-1:0] mem_dina_q;
   logic [RD_ID_W-1:0]    rd_id_q;
   logic [L-1:0]              vld_pipe_q;
   logic [L-1:0][RD_ID_W-1:0] id_pipe_q;

   sdp_rr_arb #(.N(NUM_WR), .IW(WIW)) u_wr_arb (
      .clk(clk), .reset(reset), .req(wr_req),
      .gnt(wr_gnt), .gnt_idx(wr_idx), .gnt_any(wr_any)
   );

   sdp_rr_arb #(.N(NUM_RD), .IW(RD_ID_W)) u_rd_arb (
      .clk(clk), .reset(reset), .req(rd_req),
      .gnt(rd_gnt), .gnt_idx(rd_idx), .gnt_any(rd_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_ena_q   <= 1'b0;
         mem_addra_q <= '0;
         mem_dina_q  <= '0;
         mem_enb_q   <= 1'b0;
         mem_addrb_q <= '0;
         rd_id_q     <= '0;
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
      end else begin
         mem_ena_q <= wr_any;
         if (wr_any) begin
            mem_addra_q <= wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_dina_q  <= wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];
         end
         mem_enb_q <= rd_any;
         if (rd_any) begin
            mem_addrb_q <= rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
            rd_id_q     <= rd_idx;
         end
         // Tag pipe mirrors the macro's read latency so id lines up with doutb.
         vld_pipe_q[0] <= mem_enb_q;
         id_pipe_q[0]  <= rd_id_q;
         for (int i = 1; i < L; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            id_pipe_q[i]  <= id_pipe_q[i-1];
         end
      end
   end

   assign mem_ena      = mem_ena_q;
   assign mem_wea      = mem_ena_q;
   assign mem_addra    = mem_addra_q;
   assign mem_dina     = mem_dina_q;
   assign mem_enb      = mem_enb_q;
   assign mem_addrb    = mem_addrb_q;
   assign mem_regceb   = 1'b1;
   assign mem_rstb     = reset;
   assign rd_rsp_valid = vld_pipe_q[L-1];
   assign rd_rsp_id    = id_pipe_q[L-1];
   assign rd_rsp_data  = mem_doutb;
endmodule

// File: doc/sdp_buffer_arbiter.md
# sdp_buffer_arbiter

Round-robin arbiter and sequencer that shares one simple-dual-port block-RAM buffer (`simple_dual_port_xpm`) between `NUM_WR` write requesters on port A and `NUM_RD` read requesters on port B. It registers the memory-side controls and tracks the `READ_LATENCY_B` read pipeline. It returns each read word tagged with the ID of the requester that issued it. It sits between the scratchpad/tile-load engines and the on-chip buffer macro.

## Interface
- `NUM_WR`, 2: number of write requesters (1..8).
- `NUM_RD`, 2: number of read requesters (1..8).
- `DATA_WIDTH`, 64: buffer word width; the same value is used for both memory ports.
- `ADDR_WIDTH`, 8: word address width.
- `READ_LATENCY_B`, 1: latency of the memory macro from `mem_enb` to `mem_doutb` (1..4).
- `RD_ID_W`, max(1,$clog2(NUM_RD)): width of the read-response ID.

Ports:
- `clk`  in  1  single clock for the block and the memory (common_clock).
- `reset`  in  1  synchronous, active-high reset.
- `wr_req`  in  NUM_WR  per-requester write request.
- `wr_addr`  in  NUM_WR*ADDR_WIDTH  packed write addresses; requester i occupies slice i.
- `wr_data`  in  NUM_WR*DATA_WIDTH  packed write data.
- `wr_gnt`  out  NUM_WR  one-hot write grant, combinational.
- `rd_req`  in  NUM_RD  per-requester read request.
- `rd_addr`  in  NUM_RD*ADDR_WIDTH  packed read addresses.
- `rd_gnt`  out  NUM_RD  one-hot read grant, combinational.
- `rd_rsp_valid`  out  1  read data valid.
- `rd_rsp_id`  out  RD_ID_W  index of the requester that owns `rd_rsp_data`.
- `rd_rsp_data`  out  DATA_WIDTH  read data; equals `mem_doutb`.
- `mem_ena`, `mem_wea`  out  1 each  port-A enable and write enable (both driven identically).
- `mem_addra`  out  ADDR_WIDTH  port-A address.
- `mem_dina`  out  DATA_WIDTH  port-A data.
- `mem_enb`  out  1  port-B enable.
- `mem_addrb`  out  ADDR_WIDTH  port-B address.
- `mem_regceb`  out  1  tied to 1.
- `mem_rstb`  out  1  equals `reset`.
- `mem_doutb`  in  DATA_WIDTH  port-B read data from the macro.

## Operation
- Port A and port B are arbitrated independently. Each port can grant at most one requester per cycle, so each port sustains one access per cycle.
- **Handshake:** a requester holds `req` with stable address and data until it sees `gnt`=1. The transfer occurs in the cycle where `req & gnt` are both high.
- **Grant order:** round-robin. The search starts at the port's priority pointer `ptr` and wraps modulo N. The first asserted request at or after `ptr` wins.
- **Pointer update:** after a grant to requester g, `ptr` becomes (g+1) mod N. With no grant, `ptr` holds.
- **Grant qualification:** `gnt` is 0 for any requester whose `req` is 0. With no requests, all grants are 0.
- **Write issue:** on a write grant, the next clock edge loads the memory-side registers: `mem_ena`=`mem_wea`=1, plus `mem_addra` and `mem_dina` from the winner's slice. Otherwise `mem_ena`/`mem_wea` are 0, and `mem_addra`/`mem_dina` hold their values.
- **Read issue:** on a read grant, the next edge loads `mem_enb`=1 and `mem_addrb` from the winner's slice. Otherwise `mem_enb` is 0.
- **Response tracking:** a tag shift register of depth `READ_LATENCY_B` carries (valid, id). Each stage advances every cycle.
  - Stage 0 loads from the registered `mem_enb` and its id.
  - The last stage drives `rd_rsp_valid` and `rd_rsp_id`.
  - There is no backpressure: the consumer must accept every response.
- **Same-address hazards:**
  - Read and write granted in the same cycle to the same address: both are issued, and the read returns the old data (read_first).
  - Write granted in cycle t, read to the same address granted in cycle t+1 or later: the read returns the new data.
- **Reset:**
  - Both `ptr` values go to 0.
  - `mem_ena`, `mem_wea`, `mem_enb` and every tag stage go to 0, so in-flight reads are dropped and no `rd_rsp_valid` follows reset.
  - `mem_addra`, `mem_addrb`, `mem_dina` and `rd_rsp_id` go to 0.
  - Grants are forced to 0 while `reset`=1.

## Timing
- Grant is combinational in the request cycle t.
- Memory controls are registered and active in cycle t+1.
- A write is committed to the array at the end of cycle t+1.
- Read data appears with `rd_rsp_valid`=1 in cycle t+1+`READ_LATENCY_B` (cycle t+2 at the default latency).
- Back-to-back grants on every cycle produce back-to-back responses on every cycle, in grant order.
- Grant logic depth is O(N) and must close at the buffer clock.

## Test plan
- **Reset then idle:** assert `reset` 3 cycles, then no requests -> all grants and enables 0 and `rd_rsp_valid` 0 for 20 cycles.
- **Round-robin fairness:** `rd_req`=2'b11 held for 6 cycles -> `rd_gnt` sequence 01,10,01,10,01,10. Each response appears exactly `READ_LATENCY_B`+1 cycles after its grant, with ids 0,1,0,1,0,1.
- **Write then read back:** requester 1 writes 0xDEAD_BEEF to address 0x2A in cycle t; requester 0 reads 0x2A in cycle t+1 -> `rd_rsp_data`=0xDEAD_BEEF, `rd_rsp_id`=0.
- **Same-cycle collision:** address 0x05 holds 0x11. A write of 0x22 and a read of 0x05 are granted in the same cycle -> the read returns 0x11; a subsequent read returns 0x22.
- **Reset mid-flight:** with `READ_LATENCY_B`=3, issue 3 reads, then assert `reset` one cycle after the last grant -> no `rd_rsp_valid` occurs after reset, and the next grant goes to requester 0.
- **Pointer wrap with sparse requests:** `NUM_WR`=4, only requesters 3 and 0 request -> grants alternate 3,0,3,0.
